// File: rtl/uart_pkg.sv
// Shared definitions for the UART word transmitter slice.
//   - Frame geometry (8N1: start + 8 data + stop) and line idle level.
//   - Default bit period for a 100 MHz clock at 115200 baud.
//   - State encodings for the byte serializer and the word sequencer.
package uart_pkg;

   localparam int unsigned UART_FRAME_BITS           = 10;
   localparam logic        UART_IDLE_LEVEL           = 1'b1;
   localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;

   // Byte serializer states.
   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } byte_state_e;

   // Word sequencer states.
   typedef enum logic {
      StWordIdle,
      StWordBusy
   } word_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with an internal baud counter.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      load data and begin a frame; honoured in idle and in the last
//              cycle of a stop bit, so consecutive bytes run with no gap
//   data       byte to send, sampled on the edge where start is high
//   tx         registered serial line, idle high
//   byte_done  high during the final cycle of the stop bit
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done
);

   localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned DataBits = UART_FRAME_BITS - 2;

   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      BitLast = 3'(DataBits - 1);

   byte_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      byte_q, byte_d;
   logic            tx_q, tx_d;
   logic            cnt_last;

   assign cnt_last  = (cnt_q == CntLast);
   // Combinational so the word sequencer can chain the next byte on the
   // same edge that ends this stop bit.
   assign byte_done = (state_q == StStop) && cnt_last;
   assign tx        = tx_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      byte_d    = byte_q;
      tx_d      = tx_q;

      unique case (state_q)
         StIdle: begin
            // Baud counter is held at zero while idle.
            cnt_d = '0;
            tx_d  = UART_IDLE_LEVEL;
            if (start) begin
               byte_d  = data;
               tx_d    = ~UART_IDLE_LEVEL;
               state_d = StStart;
            end
         end

         StStart: begin
            if (cnt_last) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               tx_d      = byte_q[0];
               state_d   = StData;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StData: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (bit_idx_q == BitLast) begin
                  tx_d    = UART_IDLE_LEVEL;
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = byte_q[bit_idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StStop: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (start) begin
                  byte_d  = data;
                  tx_d    = ~UART_IDLE_LEVEL;
                  state_d = StStart;
               end else begin
                  tx_d    = UART_IDLE_LEVEL;
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         default: begin
            cnt_d   = '0;
            tx_d    = UART_IDLE_LEVEL;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         byte_q    <= 8'd0;
         tx_q      <= UART_IDLE_LEVEL;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         byte_q    <= byte_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// FIFO-fed UART word transmitter. Pops one DATA_WIDTH-bit word from the
// sample FIFO and sends it most-significant byte first, each byte as an 8N1
// frame, with no idle gap between the bytes of a word.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   data_in        word presented by the FIFO
//   data_in_valid  FIFO holds a valid word on data_in
//   data_in_read   one-cycle pop strobe to the FIFO (registered)
//   tx             UART serial line, idle high (registered)
//   busy           high from word capture until the return to idle (registered)
//   word_done      one-cycle pulse after the last stop bit of a word (registered)
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic                  data_in_read,
   output logic                  tx,
   output logic                  busy,
   output logic                  word_done
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [IdxW-1:0] IdxLast = IdxW'(BYTES - 1);

   word_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [DATA_WIDTH-1:0] word_shift;
   logic [IdxW-1:0]       byte_idx_q, byte_idx_d;
   logic                  read_q, read_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  byte_start;
   logic [7:0]            byte_data;
   logic                  byte_done;

   // word_q always holds the byte currently on the line in its top lane, so
   // the next lower byte is the top lane of the shifted copy.
   assign word_shift = word_q << 8;

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      read_d     = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      byte_start = 1'b0;
      byte_data  = word_shift[DATA_WIDTH-1 -: 8];

      unique case (state_q)
         StWordIdle: begin
            if (data_in_valid) begin
               // Latch on the same edge that schedules the pop, so the FIFO
               // advancing to its next word cannot disturb this one.
               word_d     = data_in;
               byte_idx_d = '0;
               read_d     = 1'b1;
               busy_d     = 1'b1;
               byte_start = 1'b1;
               byte_data  = data_in[DATA_WIDTH-1 -: 8];
               state_d    = StWordBusy;
            end
         end

         StWordBusy: begin
            if (byte_done) begin
               if (byte_idx_q != IdxLast) begin
                  byte_idx_d = byte_idx_q + IdxW'(1);
                  word_d     = word_shift;
                  byte_start = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StWordIdle;
               end
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = StWordIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StWordIdle;
         word_q     <= '0;
         byte_idx_q <= '0;
         read_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         read_q     <= read_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_tx (
      .clk       (clk),
      .rst       (rst),
      .start     (byte_start),
      .data      (byte_data),
      .tx        (tx),
      .byte_done (byte_done)
   );

   assign data_in_read = read_q;
   assign busy         = busy_q;
   assign word_done    = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at 4 clocks per bit: a UART receiver model
// decodes the line, monitors log pop strobes and word_done pulses by cycle.
module tb_uart_word_tx;

   localparam int unsigned CPB = 4;

   logic        clk;
   logic        rst;
   logic [31:0] data_in;
   logic        data_in_valid;
   logic        data_in_read;
   logic        tx;
   logic        busy;
   logic        word_done;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;

   int          rd_q[$];
   int          wd_q[$];
   logic [7:0]  rx_q[$];
   logic        stop_q[$];

   uart_word_tx #(
      .DATA_WIDTH   (32),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_read  (data_in_read),
      .tx            (tx),
      .busy          (busy),
      .word_done     (word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_in_read === 1'b1) rd_q.push_back(cyc);
      if (word_done === 1'b1) wd_q.push_back(cyc);
   end

   // Receiver: detect start, sample mid-bit.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            stop_q.push_back(tx);
            rx_q.push_back(b);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic wait_rd(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (data_in_read === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_wd(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (word_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [31:0] rx_word(input int base);
      if (rx_q.size() < base + 4) return 32'hxxxx_xxxx;
      return {rx_q[base], rx_q[base+1], rx_q[base+2], rx_q[base+3]};
   endfunction

   function automatic int stop_errs(input int base, input int n);
      int e = 0;
      for (int i = base; i < base + n; i++) begin
         if (i >= stop_q.size() || stop_q[i] !== 1'b1) e++;
      end
      return e;
   endfunction

   // Send one word from an idle FIFO slot and check timing and content.
   task automatic run_word(input string tag, input logic [31:0] w, output int rcyc);
      int base;
      bit ok;
      base          = rx_q.size();
      data_in       = w;
      data_in_valid = 1'b1;
      wait_rd(300, ok);
      check({tag, "_read_seen"}, 32'(ok), 32'd1);
      data_in_valid = 1'b0;
      rcyc          = cyc;
      @(negedge clk);
      check({tag, "_read_pulse"}, 32'(data_in_read), 32'd0);
      wait_wd(300, ok);
      check({tag, "_done_seen"}, 32'(ok), 32'd1);
      check({tag, "_latency"}, 32'(cyc - rcyc), 32'd160);
      check({tag, "_bytes"}, rx_word(base), w);
      check({tag, "_stop_bits"}, 32'(stop_errs(base, 4)), 32'd0);
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_done_pulse"}, 32'(word_done), 32'd0);
   endtask

   initial begin
      int         rcyc, rel_cyc, r0, base, rd_base, wd_base, errs;
      bit         ok;
      logic [9:0] a1_stream;

      // Reset held with valid high: rst wins.
      rst           = 1'b1;
      data_in_valid = 1'b1;
      data_in       = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_tx", 32'(tx), 32'd1);
         check("rst_read", 32'(data_in_read), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rel_no_read", 32'(data_in_read), 32'd0);
      rel_cyc = cyc;
      run_word("rel", 32'hDEAD_BEEF, rcyc);
      check("rel_read_cycle", 32'(rcyc - rel_cyc), 32'd1);

      // Single word with bit-level line check of the first frame.
      repeat (3) @(negedge clk);
      base          = rx_q.size();
      a1_stream     = 10'b11_0100_0010;
      data_in       = 32'hA1B2_C3D4;
      data_in_valid = 1'b1;
      wait_rd(50, ok);
      check("a1_read_seen", 32'(ok), 32'd1);
      data_in_valid = 1'b0;
      r0            = cyc;
      errs          = 0;
      for (int i = 0; i < 40; i++) begin
         if (tx !== a1_stream[i / 4]) errs++;
         if (i == 1) check("a1_read_pulse", 32'(data_in_read), 32'd0);
         if (i == 20) check("a1_busy_mid", 32'(busy), 32'd1);
         if (i < 39) @(negedge clk);
      end
      check("a1_stream", 32'(errs), 32'd0);
      wait_wd(300, ok);
      check("a1_done_seen", 32'(ok), 32'd1);
      check("a1_latency", 32'(cyc - r0), 32'd160);
      check("a1_bytes", rx_word(base), 32'hA1B2_C3D4);
      @(negedge clk);
      check("a1_done_pulse", 32'(word_done), 32'd0);
      check("a1_busy_after", 32'(busy), 32'd0);

      // Back-to-back: two-word FIFO, valid held until the FIFO drains.
      base          = rx_q.size();
      rd_base       = rd_q.size();
      wd_base       = wd_q.size();
      data_in       = 32'h0000_0001;
      data_in_valid = 1'b1;
      wait_rd(50, ok);
      check("b2b_read1_seen", 32'(ok), 32'd1);
      data_in = 32'hFFFF_FFFF;
      wait_rd(400, ok);
      check("b2b_read2_seen", 32'(ok), 32'd1);
      data_in_valid = 1'b0;
      wait_wd(400, ok);
      check("b2b_done2_seen", 32'(ok), 32'd1);
      repeat (5) @(negedge clk);
      check("b2b_read_count", 32'(rd_q.size() - rd_base), 32'd2);
      check("b2b_read_spacing", 32'(rd_q[rd_base+1] - rd_q[rd_base]), 32'd161);
      check("b2b_done_count", 32'(wd_q.size() - wd_base), 32'd2);
      check("b2b_word1", rx_word(base), 32'h0000_0001);
      check("b2b_word2", rx_word(base + 4), 32'hFFFF_FFFF);
      check("b2b_stop_bits", 32'(stop_errs(base, 8)), 32'd0);

      // Valid held through busy; data_in changes mid-frame.
      base          = rx_q.size();
      rd_base       = rd_q.size();
      data_in       = 32'h1357_9BDF;
      data_in_valid = 1'b1;
      wait_rd(50, ok);
      check("hold_read_seen", 32'(ok), 32'd1);
      repeat (30) @(negedge clk);
      data_in = 32'hFFFF_FFFF;
      repeat (60) @(negedge clk);
      data_in = 32'h0000_0000;
      wait_wd(300, ok);
      check("hold_done_seen", 32'(ok), 32'd1);
      data_in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("hold_read_count", 32'(rd_q.size() - rd_base), 32'd1);
      check("hold_bytes", rx_word(base), 32'h1357_9BDF);

      // Empty FIFO.
      rd_base = rd_q.size();
      wd_base = wd_q.size();
      errs    = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      check("empty_line_idle", 32'(errs), 32'd0);
      check("empty_read_count", 32'(rd_q.size() - rd_base), 32'd0);
      check("empty_done_count", 32'(wd_q.size() - wd_base), 32'd0);

      // Reset during byte 2 data bit 0 (0xFE bit0 = 0, line low).
      data_in       = 32'hCAFE_F00D;
      data_in_valid = 1'b1;
      wait_rd(50, ok);
      check("mid_read_seen", 32'(ok), 32'd1);
      data_in_valid = 1'b0;
      repeat (45) @(negedge clk);
      check("mid_pre_tx", 32'(tx), 32'd0);
      check("mid_pre_busy", 32'(busy), 32'd1);
      rd_base = rd_q.size();
      wd_base = wd_q.size();
      rst     = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("mid_no_done", 32'(wd_q.size() - wd_base), 32'd0);
      check("mid_no_read", 32'(rd_q.size() - rd_base), 32'd0);
      check("mid_idle_tx", 32'(tx), 32'd1);
      run_word("post_rst", 32'h1234_5678, rcyc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Downstream consumer of the sample FIFO: pops one DATA_WIDTH-bit word at a time and serializes it over a UART TX line to the host PC.
- Each word is sent as DATA_WIDTH/8 bytes, most-significant byte first. Each byte uses 8N1 framing, LSB bit first.
- Connects directly to the FIFO output side: data_out → data_in, data_out_valid → data_in_valid, data_in_read → data_out_read.

Parameters:
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200 baud); minimum 2.
- BYTES, DATA_WIDTH/8: bytes per word (localparam).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data_in  input  DATA_WIDTH  word presented by the FIFO
- data_in_valid  input  1  FIFO holds a valid word on data_in
- data_in_read  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  UART serial line, idle high
- busy  output  1  high from word capture until the return to IDLE
- word_done  output  1  one-cycle pulse after the last stop bit of a word

Behaviour:
- Reset values: tx=1, data_in_read=0, busy=0, word_done=0. Internal state: FSM=IDLE, all counters=0, shift register=0.
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If data_in_valid=1 at edge E: latch data_in into word_reg, assert data_in_read for exactly the cycle after E, set busy=1, load the top byte, go to START.
  - tx goes low in the cycle after E.
  - If data_in_valid=0: remain in IDLE, tx=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx = byte_reg[bit_idx], each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - If byte_idx < BYTES-1: increment byte_idx, load the next lower byte, go to START. No idle gap between bytes.
  - Else: pulse word_done=1 for one cycle, clear busy, go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Never free-runs in IDLE; held at 0 there.
- Word timing:
  - Capture to word_done = BYTES*10*CLKS_PER_BIT cycles.
  - Minimum spacing between successive captures = BYTES*10*CLKS_PER_BIT + 1 cycles, because IDLE is held for one cycle.
- Handshake rules:
  - data_in_read is asserted only in response to data_in_valid=1 while in IDLE. It never fires while busy=1, even if data_in_valid stays high.
  - The word is latched on the same edge that schedules the pop, so the FIFO's next-word update cannot corrupt it.
  - data_in is ignored whenever busy=1.
- FIFO empty: data_in_valid=0 → stay in IDLE indefinitely, no strobe, tx=1.
- Reset mid-frame: on the next edge return to IDLE with tx=1 and busy=0. The partially sent word is discarded (it has already been popped). No word_done pulse.
- Simultaneous rst and data_in_valid: rst wins; no data_in_read.

Decomposition:
- Shared package (uart_pkg):
  - FSM state encoding localparams
  - UART_FRAME_BITS=10
  - UART_IDLE_LEVEL=1'b1
  - default CLKS_PER_BIT
- Sub-module uart_byte_tx (START/DATA/STOP, baud counter, tx register, byte_done pulse).
  - uart_word_tx keeps word capture, the pop strobe, byte sequencing (byte_idx) and busy/word_done.

Test Plan:
- Reset: CLKS_PER_BIT=4, hold rst 3 cycles with data_in_valid=1 → tx=1, data_in_read=0, busy=0 throughout; no read after release until one cycle after the first IDLE edge.
- Single word: data_in=32'hA1B2C3D4 with valid for one capture → data_in_read high exactly 1 cycle; bytes decoded A1,B2,C3,D4; byte A1 bit stream 0,1,0,0,0,0,1,0,1,1 with 4 cycles per bit; word_done at capture+160 cycles.
- Back-to-back: FIFO model with 2 words (32'h00000001, 32'hFFFFFFFF), valid held high → exactly 2 read strobes, 161 cycles apart; decoded 00,00,00,01,FF,FF,FF,FF; 2 word_done pulses.
- Valid held during busy: data_in_valid constantly 1 with a 1-word FIFO → only 1 data_in_read; changing data_in mid-frame does not alter the transmitted bytes.
- Empty FIFO: data_in_valid=0 for 500 cycles → tx=1, busy=0, no data_in_read.
- Reset mid-frame: assert rst during the DATA state of byte 2 → next cycle tx=1, busy=0, no word_done; then a new word 32'h12345678 transmits correctly as 12,34,56,78.
